priority_encoder_16x4: RTL
==========================

Name: priority_encoder_16x4

Overview:
- Sequential 16-to-4 encoder. It is the inverse of the 4x16 decoder path.
- Accepts a 16-bit request vector over a valid/ready handshake.
- Emits the 4-bit index of every set bit, lowest index first, one code per accepted output beat.
- Sits upstream of decoder_4x16; the serialised codes and enable drive the decoder address/enable inputs.

Parameters:
- N_IN, 16, request vector width. Fixed at 16 for this block.
- CODE_W, 4, code width, equal to log2(N_IN).

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- e  input  1  enable; gates acceptance of new vectors
- req  input  16  request vector, bit i requests code i
- req_valid  input  1  req is valid
- req_ready  output  1  block can capture req
- code  output  4  index of lowest pending request
- code_valid  output  1  code is valid
- code_ready  input  1  consumer accepts code
- last  output  1  current code is the final one of the vector
- cnt  output  5  pending codes remaining, 0..16
- none  output  1  one-cycle pulse: an all-zero vector was accepted

Behaviour:
- Reset (rst=1 at a clk edge):
  - state=IDLE, pend=16'h0000, cnt=0.
  - code_valid=0, none=0.
  - code=0 and last=0, because they are derived from pend=0.
  - req_ready follows e once in IDLE.
- States: IDLE, SCAN.
- IDLE:
  - req_ready = e.
  - On req_valid && req_ready with req!=0: pend<=req, cnt<=popcount(req), state<=SCAN.
  - On the same handshake with req==0: none=1 for exactly one cycle. No code is emitted and the state stays IDLE.
- SCAN:
  - req_ready=0 and code_valid=1.
  - code = index of the lowest set bit of pend.
  - last = (cnt==1).
  - code and last are combinational from registered pend/cnt only; there is no input-to-output combinational path.
  - On code_valid && code_ready: clear that bit in pend and decrement cnt.
  - If last was 1, state<=IDLE, and code_valid is 0 in the next cycle.
- Latency: a vector captured at edge k gives its first code valid in cycle k+1.
- Throughput: one code per cycle while code_ready=1.
- Turnaround: after the final handshake, req_ready=1 (if e=1) in the next cycle. A new vector cannot be captured in the same cycle as the final code handshake.
- Backpressure: while code_ready=0, code, last and cnt hold stable and code_valid stays 1.
- Enable: e=0 in IDLE blocks acceptance. e=0 during SCAN has no effect; the burst completes.
- Reset mid-SCAN: at the next edge, pend is cleared, cnt=0, code_valid=0, state=IDLE. No partial burst resumes.
- Boundaries:
  - req=16'hFFFF gives cnt=16 and codes 0..15 in order.
  - A single set bit gives one beat with last=1.
  - req_valid changes while req_ready=0 are ignored.

Decomposition:
- Package enc_pkg holds:
  - N_IN and CODE_W constants.
  - The state type enum (IDLE, SCAN).
  - The popcount width constant (CODE_W+1).
- One sub-module, pri_enc_ffs:
  - Combinational find-first-set over 16 bits.
  - Outputs the 4-bit index and an any-set flag.
  - Used for code generation and the clear-mask computation.

Test Plan:
1. rst=1 for 2 cycles, then e=1 → req_ready=1, code_valid=0, cnt=0, none=0.
2. req=16'h8421, req_valid pulse, code_ready=1:
   - codes 0,5,10,15 on consecutive cycles with cnt 4,3,2,1.
   - last=1 only with code 15.
   - req_ready=1 in the cycle after.
3. req=16'h0003, code_ready=0 for 3 cycles then 1:
   - code=0 held valid for 3 cycles, then 0 and 1 accepted.
   - last on code 1.
4. req=16'h0000 accepted → none=1 for one cycle, code_valid stays 0, req_ready stays 1.
5. e=0 with req_valid=1, req=16'h0010 → req_ready=0 and no capture. Raise e → capture, then code=4 with last=1.
6. req=16'h00F0, rst asserted after codes 4 and 5 are accepted → next cycle code_valid=0, cnt=0, state IDLE. Codes 6 and 7 are never emitted.

Source files
------------

// File: rtl/enc_pkg.sv
// -----------------------------------------------------------------------------
// enc_pkg
// Shared constants, the sequencer state type and a population-count helper
// for the serialising 16-to-4 priority encoder.
// -----------------------------------------------------------------------------
package enc_pkg;

   localparam int N_IN   = 16;          // request vector width
   localparam int CODE_W = 4;           // log2(N_IN)
   localparam int CNT_W  = CODE_W + 1;  // holds 0..N_IN pending codes

   typedef enum logic [0:0] {
      IDLE = 1'b0,
      SCAN = 1'b1
   } state_t;

   // Number of set bits in a request vector; seeds the pending-code counter.
   function automatic logic [CNT_W-1:0] popcount(input logic [N_IN-1:0] vec);
      logic [CNT_W-1:0] sum;
      sum = {CNT_W{1'b0}};
      for (int i = 0; i < N_IN; i++) begin
         sum = sum + {{(CNT_W-1){1'b0}}, vec[i]};
      end
      return sum;
   endfunction

endpackage : enc_pkg

// File: rtl/pri_enc_ffs.sv
// -----------------------------------------------------------------------------
// pri_enc_ffs
// Combinational find-first-set: index of the lowest set bit of a 16-bit vector.
// Ports:
//   vec  in  [N_IN-1:0]   vector to search
//   idx  out [CODE_W-1:0] index of the lowest set bit (0 when vec is zero)
//   any  out 1            at least one bit of vec is set
// -----------------------------------------------------------------------------
module pri_enc_ffs
   import enc_pkg::*;
(
   input  logic [N_IN-1:0]   vec,
   output logic [CODE_W-1:0] idx,
   output logic              any
);

   // Scan from the top down so the lowest set bit is the last one to win.
   always_comb begin
      idx = {CODE_W{1'b0}};
      any = |vec;
      for (int i = N_IN - 1; i >= 0; i--) begin
         idx = vec[i] ? CODE_W'(i) : idx;
      end
   end

endmodule : pri_enc_ffs

// File: rtl/priority_encoder_16x4.sv
// -----------------------------------------------------------------------------
// priority_encoder_16x4
// Captures a 16-bit request vector and serialises the index of every set bit,
// lowest first, one code per accepted output beat. Feeds decoder_4x16.
// Ports:
//   clk         in   rising-edge clock
//   rst         in   synchronous active-high reset
//   e           in   enable; gates acceptance of new vectors in IDLE
//   req         in   [15:0] request vector
//   req_valid   in   req is valid
//   req_ready   out  block can capture req (IDLE and e)
//   code        out  [3:0] index of the lowest pending request
//   code_valid  out  code is valid (SCAN)
//   code_ready  in   consumer accepts code
//   last        out  current code is the final one of the vector
//   cnt         out  [4:0] pending codes remaining
//   none        out  one-cycle pulse after an all-zero vector was accepted
// -----------------------------------------------------------------------------
module priority_encoder_16x4
   import enc_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic              e,
   input  logic [N_IN-1:0]   req,
   input  logic              req_valid,
   output logic              req_ready,
   output logic [CODE_W-1:0] code,
   output logic              code_valid,
   input  logic              code_ready,
   output logic              last,
   output logic [CNT_W-1:0]  cnt,
   output logic              none
);

   state_t             state_r;
   state_t             state_nx_s;
   logic [N_IN-1:0]    pend_r;
   logic [N_IN-1:0]    pend_nx_s;
   logic [CNT_W-1:0]   cnt_r;
   logic [CNT_W-1:0]   cnt_nx_s;
   logic               none_r;
   logic               none_nx_s;

   logic [CODE_W-1:0]  code_s;
   logic               any_s;
   logic [N_IN-1:0]    clr_mask_s;
   logic               accept_s;
   logic               beat_s;
   logic               last_s;

   pri_enc_ffs u_ffs (
      .vec (pend_r),
      .idx (code_s),
      .any (any_s)
   );

   // One-hot mask of the code currently being presented; cleared on a beat.
   assign clr_mask_s = {{(N_IN-1){1'b0}}, 1'b1} << code_s;

   assign accept_s = (state_r == IDLE) && e && req_valid;
   assign beat_s   = (state_r == SCAN) && code_ready && any_s;
   assign last_s   = (state_r == SCAN) && (cnt_r == CNT_W'(1));

   // Next-state, pending-vector and counter update.
   always_comb begin
      state_nx_s = state_r;
      pend_nx_s  = pend_r;
      cnt_nx_s   = cnt_r;
      none_nx_s  = 1'b0;
      case (state_r)
         IDLE: begin
            if (accept_s) begin
               if (req != {N_IN{1'b0}}) begin
                  pend_nx_s  = req;
                  cnt_nx_s   = popcount(req);
                  state_nx_s = SCAN;
               end else begin
                  none_nx_s  = 1'b1;
               end
            end else begin
               state_nx_s = IDLE;
            end
         end
         SCAN: begin
            if (beat_s) begin
               pend_nx_s = pend_r & ~clr_mask_s;
               cnt_nx_s  = cnt_r - CNT_W'(1);
               if (last_s) begin
                  state_nx_s = IDLE;
               end else begin
                  state_nx_s = SCAN;
               end
            end else begin
               state_nx_s = SCAN;
            end
         end
         default: begin
            state_nx_s = IDLE;
            pend_nx_s  = {N_IN{1'b0}};
            cnt_nx_s   = {CNT_W{1'b0}};
         end
      endcase
   end

   // State, pending vector, counter and none pulse registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r <= IDLE;
         pend_r  <= {N_IN{1'b0}};
         cnt_r   <= {CNT_W{1'b0}};
         none_r  <= 1'b0;
      end else begin
         state_r <= state_nx_s;
         pend_r  <= pend_nx_s;
         cnt_r   <= cnt_nx_s;
         none_r  <= none_nx_s;
      end
   end

   // Outputs derive from registered state only, except req_ready which
   // follows the enable while idle.
   assign req_ready  = (state_r == IDLE) && e;
   assign code_valid = (state_r == SCAN);
   assign code       = code_s;
   assign last       = last_s;
   assign cnt        = cnt_r;
   assign none       = none_r;

endmodule : priority_encoder_16x4
